// File: rtl/bsg_link_credit_tx_mux.sv
// ---------------------------------------------------------------------------
// bsg_link_credit_tx_mux: credit-gated round-robin mux of core channels onto
// one registered link.                                         Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_link_credit_tx_mux #(
  parameter int width_p        = 16,
  parameter int num_chan_p     = 4,
  parameter int credit_depth_p = 8,
  parameter int token_batch_p  = 1
) (
  input  logic                                           core_clk_i,
  input  logic                                           core_reset_n_i,
  input  logic [num_chan_p*width_p-1:0]                  core_data_i,
  input  logic [num_chan_p-1:0]                          core_valid_i,
  output logic [num_chan_p-1:0]                          core_ready_o,
  input  logic [num_chan_p-1:0]                          token_i,
  output logic [width_p-1:0]                             link_data_r_o,
  output logic [((num_chan_p > 1) ? $clog2(num_chan_p) : 1)-1:0] link_chan_r_o,
  output logic                                           link_valid_r_o,
  output logic                                           credit_err_r_o
);

  localparam int c_chan_w = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
  localparam int c_cred_w = $clog2(credit_depth_p + 1);
  // One extra bit so credit + token batch can be compared against the depth
  localparam int c_sum_w  = c_cred_w + 1;
  localparam logic [c_sum_w-1:0]  c_depth_s   = c_sum_w'(credit_depth_p);
  localparam logic [c_sum_w-1:0]  c_batch_s   = c_sum_w'(token_batch_p);
  localparam logic [c_cred_w-1:0] c_depth_c   = c_cred_w'(credit_depth_p);
  localparam logic [c_chan_w-1:0] c_last_init = c_chan_w'(num_chan_p - 1);

  logic [num_chan_p-1:0] w_elig;
  logic [num_chan_p-1:0] w_ready;
  logic [num_chan_p-1:0] w_xfer;
  logic [num_chan_p-1:0] w_ovf;
  logic [c_chan_w-1:0]   w_grant;
  logic [c_chan_w-1:0]   w_sel;
  logic                  w_any;
  logic [c_chan_w-1:0]   r_last_grant;

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    logic [c_cred_w-1:0] r_credit;
    logic [c_sum_w-1:0]  w_sum;

    assign w_elig[c] = core_valid_i[c] & (r_credit != '0);

    always_comb begin
      w_sum = {1'b0, r_credit};
      if (token_i[c]) w_sum = w_sum + c_batch_s;
      if (w_xfer[c])  w_sum = w_sum - c_sum_w'(1);
    end

    assign w_ovf[c] = (w_sum > c_depth_s);

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i)  r_credit <= c_depth_c;
      else if (w_ovf[c])    r_credit <= c_depth_c;
      else                  r_credit <= w_sum[c_cred_w-1:0];
    end
  end

  // Search begins one past the last granted channel; first eligible wins
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_last_grant;
    w_sel   = '0;
    for (int i = 1; i <= num_chan_p; i++) begin
      w_sel = c_chan_w'((int'(r_last_grant) + i) % num_chan_p);
      if (!w_any && w_elig[w_sel]) begin
        w_any   = 1'b1;
        w_grant = w_sel;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_any && core_reset_n_i) w_ready[w_grant] = 1'b1;
  end

  assign core_ready_o = w_ready;
  assign w_xfer       = w_ready & core_valid_i;

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      link_valid_r_o <= 1'b0;
      link_data_r_o  <= '0;
      link_chan_r_o  <= '0;
      credit_err_r_o <= 1'b0;
      r_last_grant   <= c_last_init;
    end else begin
      link_valid_r_o <= |w_xfer;
      if (|w_xfer) begin
        link_data_r_o <= core_data_i[w_grant*width_p +: width_p];
        link_chan_r_o <= w_grant;
        r_last_grant  <= w_grant;
      end
      if (|w_ovf) credit_err_r_o <= 1'b1;
    end
  end

endmodule

`default_nettype wire
